// File: rtl/logic_arb_pkg.sv
// -----------------------------------------------------------------------------
// logic_arb_pkg
// Shared definitions for the two-requester bitwise-logic arbiter.
//   LOGIC_ARB_WIDTH : default operand/result width
//   op_e            : opcode encoding (AND, OR, XOR, NOR)
//   state_e         : arbiter FSM states (IDLE, EXEC, RESP)
// -----------------------------------------------------------------------------
package logic_arb_pkg;

  localparam int LOGIC_ARB_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit4.sv
// -----------------------------------------------------------------------------
// logic_unit4
// Purely combinational opcode-to-result function.
// Ports:
//   i_op  : opcode (op_e)
//   i_a   : operand A, WIDTH bits
//   i_b   : operand B, WIDTH bits
//   o_y   : result, WIDTH bits (no carry or extension)
// -----------------------------------------------------------------------------
module logic_unit4
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = LOGIC_ARB_WIDTH
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NOR:  o_y = ~(i_a | i_b);
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/logic_arbiter4.sv
// -----------------------------------------------------------------------------
// logic_arbiter4
// Round-robin arbiter between two requesters that each submit a bitwise logic
// operation. One operation is in flight at a time: IDLE -> EXEC -> RESP.
// Optional feature: define LOGIC_ARB_STATS_EN to add saturating per-requester
// grant counters (grant_cnt0 / grant_cnt1).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   reqN_valid / reqN_ready    : request handshake (N = 0, 1)
//   reqN_op, reqN_a, reqN_b    : opcode and operands
//   res_valid / res_ready      : result handshake
//   res_data, res_id           : result and owning requester index
//   grant_cnt0, grant_cnt1     : accepted-transfer counters (stats build only)
// -----------------------------------------------------------------------------
module logic_arbiter4
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = LOGIC_ARB_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
`ifdef LOGIC_ARB_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
`endif
  output logic             res_id
);

  state_e           r_state;
  logic             r_last_grant;
  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_id;

  logic             w_idle;
  logic             w_any_valid;
  logic             w_grant1;
  logic             w_accept;
  op_e              w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;

  // Gating with rst_n keeps both readies low while reset is held.
  assign w_idle      = rst_n && (r_state == ST_IDLE);
  assign w_any_valid = req0_valid || req1_valid;

  // With both valid, the requester not granted last wins; otherwise the
  // single valid requester wins. r_last_grant resets to 1 so req0 goes first.
  assign w_grant1 = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  assign req0_ready = w_idle && w_any_valid && !w_grant1;
  assign req1_ready = w_idle && w_any_valid &&  w_grant1;
  assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign w_op = w_grant1 ? op_e'(req1_op) : op_e'(req0_op);
  assign w_a  = w_grant1 ? req1_a : req0_a;
  assign w_b  = w_grant1 ? req1_b : req0_b;

  logic_unit4 #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_op         <= OP_AND;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_res_data   <= '0;
      r_res_id     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op         <= w_op;
            r_a          <= w_a;
            r_b          <= w_b;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res_data <= w_result;
          r_res_id   <= r_id;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          // Result registers are untouched here, so they hold under backpressure.
          if (res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign res_valid = (r_state == ST_RESP);
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

`ifdef LOGIC_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_accept) begin
      if (!w_grant1 && (r_cnt0 != '1)) begin
        r_cnt0 <= r_cnt0 + 1'b1;
      end
      if (w_grant1 && (r_cnt1 != '1)) begin
        r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_logic_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_logic_arbiter4
// Self-checking bench for logic_arbiter4. A negedge monitor tracks the
// expected FSM phase and round-robin grant, pushes expected results into a
// scoreboard queue at each accept and pops them at each result handshake.
// Directed sequences add explicit constant checks.
// -----------------------------------------------------------------------------
module tb_logic_arbiter4;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready;
  logic [W-1:0] res_data;
  logic         res_id;
`ifdef LOGIC_ARB_STATS_EN
  logic [7:0]   grant_cnt0, grant_cnt1;
`endif

  logic_arbiter4 #(.WIDTH(W), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
`ifdef LOGIC_ARB_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .res_id     (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         sb_e;
  int           phase;      // 0 idle, 1 exec, 2 resp
  logic         last_m;
  logic         held;
  logic [W-1:0] hold_data;
  logic         hold_id;
  logic         g_m;
  logic [1:0]   exp_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_ready", {req1_ready, req0_ready}, 0);
`ifdef LOGIC_ARB_STATS_EN
      chk("rst_cnt0", grant_cnt0, 0);
      chk("rst_cnt1", grant_cnt1, 0);
`endif
      sb_q.delete();
      phase  = 0;
      last_m = 1'b1;
      held   = 1'b0;
    end else begin
      chk("res_valid", res_valid, (phase == 2));
      exp_rdy = 2'b00;
      g_m     = 1'b0;
      if (phase == 0 && (req0_valid || req1_valid)) begin
        g_m     = (req0_valid && req1_valid) ? !last_m : req1_valid;
        exp_rdy = g_m ? 2'b10 : 2'b01;
      end
      chk("ready", {req1_ready, req0_ready}, exp_rdy);
      if (phase == 2 && held) begin
        chk("hold_data", res_data, hold_data);
        chk("hold_id", res_id, hold_id);
      end
      held      = (phase == 2) && !res_ready;
      hold_data = res_data;
      hold_id   = res_id;
      if (phase == 0) begin
        if (exp_rdy != 2'b00) begin
          sb_e.id   = g_m;
          sb_e.data = g_m ? model(req1_op, req1_a, req1_b) : model(req0_op, req0_a, req0_b);
          sb_q.push_back(sb_e);
          last_m = g_m;
          phase  = 1;
        end
      end else if (phase == 1) begin
        phase = 2;
      end else if (res_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          sb_e = sb_q.pop_front();
          chk("res_data", res_data, sb_e.data);
          chk("res_id", res_id, sb_e.id);
        end
        phase = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one request until accepted; returns at accept edge + 1.
  task automatic send(input int id, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    logic got;
    got = 1'b0;
    if (id == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = (id == 0) ? req0_ready : req1_ready;
    end
    if (!got) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  // Counts negedges until res_valid; returns at that negedge.
  task automatic wait_result(output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      lat++;
      seen = res_valid;
    end
    if (!seen) chk("result_timeout", 0, 1);
  endtask

  task automatic do_op(input string tag, input int id, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    int lat;
    send(id, op, a, b);
    wait_result(lat);
    chk(tag, res_data, exp);
    @(posedge clk); #1;
  endtask

  logic glog[$];
  int   lat;

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;

    // Single request, latency and return to idle
    send(0, 2'b01, 4'h5, 4'hA);
    wait_result(lat);
    chk("t1_latency", lat, 2);
    chk("t1_data", res_data, 4'hF);
    chk("t1_id", res_id, 0);
    @(negedge clk);
    chk("t1_idle_rv", res_valid, 0);
    $display("t1 single OR 5|A -> %0h id %0d", 4'hF, 0);

    // Both requesters valid continuously: grants alternate from req0
    do_reset(2);
    req0_op = 2'b01; req0_a = 4'h3; req0_b = 4'h4;
    req1_op = 2'b00; req1_a = 4'hC; req1_b = 4'hA;
    req0_valid = 1'b1; req1_valid = 1'b1;
    glog.delete();
    for (int c = 0; c < 60 && glog.size() < 4; c++) begin
      @(negedge clk);
      if (req0_ready)      glog.push_back(1'b0);
      else if (req1_ready) glog.push_back(1'b1);
      if (res_valid && res_id) chk("t2_and", res_data, 4'h8);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2_ngrants", glog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_grant%0d", i), (i < glog.size()) ? 32'(glog[i]) : 32'hDEAD, i % 2);
    end
    repeat (4) @(posedge clk); #1;
    $display("t2 alternating grants, %0d logged", glog.size());

    // Backpressure: hold result 5 cycles with req1 pending
    res_ready = 1'b0;
    send(0, 2'b10, 4'h3, 4'h5);
    req1_op = 2'b01; req1_a = 4'h1; req1_b = 4'h2; req1_valid = 1'b1;
    wait_result(lat);
    chk("t3_data", res_data, 4'h6);
    repeat (5) @(negedge clk);
    chk("t3_hold", res_data, 4'h6);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_idle_ready1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    $display("t3 backpressure held result %0h", 4'h6);

    // Boundary values
    do_op("t4_nor00", 0, 2'b11, 4'h0, 4'h0, 4'hF);
    do_op("t4_norF0", 1, 2'b11, 4'hF, 4'h0, 4'h0);
    do_op("t4_xor99", 0, 2'b10, 4'h9, 4'h9, 4'h0);
    do_op("t4_andFF", 1, 2'b00, 4'hF, 4'hF, 4'hF);
    $display("t4 boundary ops done");

    // Reset in EXEC aborts, req0 wins afterwards
    send(1, 2'b01, 4'h7, 4'h8);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_result", res_valid, 0);
    end
    @(posedge clk); #1;
    req0_op = 2'b00; req0_a = 4'h6; req0_b = 4'h3;
    req1_op = 2'b00; req1_a = 4'h6; req1_b = 4'h3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("t5_grant0", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    $display("t5 reset abort, post-reset grant checked");

`ifdef LOGIC_ARB_STATS_EN
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      send(0, 2'b01, 4'(i), 4'(i >> 4));
      repeat (2) @(posedge clk); #1;
      if (i == 9) chk("t6_cnt0_10", grant_cnt0, 10);
    end
    chk("t6_cnt0_sat", grant_cnt0, 8'hFF);
    chk("t6_cnt1_zero", grant_cnt1, 0);
    $display("t6 stats cnt0=%0h cnt1=%0h", grant_cnt0, grant_cnt1);
`endif

    repeat (5) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_arbiter4.md
LOGIC_ARBITER4 -- requirements
Module: logic_arbiter4

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits.
REQ-002 Parameter CNT_W, default 8, width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-006 req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-007 req0_op / req1_op  input  2 each  opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer takes the result.
REQ-011 res_data  output  WIDTH  result of the bitwise operation.
REQ-012 res_id  output  1  index of the requester that owns res_data.

Function
REQ-013 FSM states SHALL be IDLE, EXEC and RESP.
REQ-014 In IDLE with at least one valid request, exactly one reqN_ready SHALL be high, combinationally; the transfer completes when valid and ready are both high. The FSM then moves to EXEC and captures op, a, b and id.
REQ-015 Arbitration SHALL be round-robin. With both valid, the grant goes to the requester not granted last. After reset, requester 0 has priority.
REQ-016 reqN_ready SHALL be low in EXEC and RESP.
REQ-017 EXEC SHALL last one cycle and register the op result into res_data and res_id, then move to RESP.
REQ-018 res_valid SHALL be high only in RESP. The first cycle of res_valid is two cycles after the accepting edge.
REQ-019 In RESP, res_data and res_id SHALL hold stable until res_valid and res_ready are both high.
REQ-020 On that handshake the FSM SHALL return to IDLE; the next accept is possible in the following cycle.
REQ-021 Results SHALL be exactly WIDTH bits, with no carry or extension. NOR is ~(a|b) truncated to WIDTH.
REQ-022 A requester that drops valid before being granted SHALL lose nothing. No state is kept for ungranted requests.
REQ-023 res_ready high while res_valid is low SHALL have no effect.

Reset
REQ-024 While rst_n is low, all outputs SHALL read as follows:
- state = IDLE.
- res_valid = 0, res_data = 0, res_id = 0.
- last-grant = 1, so that requester 0 wins first.
- counters = 0.
REQ-025 Reset asserted during EXEC or RESP SHALL abort the operation immediately. No result is delivered after reset release.
REQ-026 reqN_ready SHALL be 0 while rst_n is low.

Configuration
REQ-027 With macro LOGIC_ARB_STATS_EN defined, the block SHALL add output ports grant_cnt0 and grant_cnt1 (CNT_W each). Each port counts accepted transfers per requester and saturates at all-ones.
REQ-028 Without LOGIC_ARB_STATS_EN, those ports and their counters SHALL be absent. All other behaviour is identical.

Structure
REQ-029 Shared package logic_arb_pkg SHALL hold:
- the opcode enum (OP_AND, OP_OR, OP_XOR, OP_NOR);
- the FSM state enum;
- the default WIDTH constant.
REQ-030 Sub-module logic_unit4 SHALL implement the combinational opcode-to-result function. It is instantiated once, between the captured operands and the EXEC result register.

Verification
REQ-031 Reset, then req0 only: op=01, a=4'h5, b=4'hA, res_ready=1.
- Accept at cycle 0.
- res_valid at cycle 2 with res_data=4'hF, res_id=0.
- IDLE at cycle 3.
REQ-032 Both requesters valid continuously, res_ready=1. Grants SHALL alternate 0,1,0,1. Check: req1 op=00, a=4'hC, b=4'hA gives res_data=4'h8, res_id=1.
REQ-033 Backpressure: res_ready=0 for 5 cycles in RESP. res_data SHALL stay stable and both readies SHALL stay low. Raise res_ready: FSM goes to IDLE next cycle.
REQ-034 NOR boundary: a=4'h0, b=4'h0 gives 4'hF; a=4'hF, b=4'h0 gives 4'h0. XOR a=b=4'h9 gives 4'h0.
REQ-035 Assert rst_n=0 mid-EXEC. res_valid SHALL stay 0. After release, req0 SHALL win a simultaneous request.
REQ-036 With LOGIC_ARB_STATS_EN, drive 300 grants to req0. grant_cnt0 SHALL saturate at 8'hFF and grant_cnt1 SHALL stay 0.
